// File: rtl/brush_tool_pkg.sv
// Shared definitions for the brush tool: colour encoding, brush shapes
// and the stamp FSM state type. The circle brush is enabled by the
// BRUSH_CIRCLE_EN macro (see brush_mask).
package brush_tool_pkg;

    localparam int COLOR_WIDTH = 4;

    localparam logic [COLOR_WIDTH-1:0] COLOR_NONE  = 4'd0;
    localparam logic [COLOR_WIDTH-1:0] COLOR_BLACK = 4'd1;
    localparam logic [COLOR_WIDTH-1:0] COLOR_RED   = 4'd2;
    localparam logic [COLOR_WIDTH-1:0] COLOR_GREEN = 4'd3;
    localparam logic [COLOR_WIDTH-1:0] COLOR_BLUE  = 4'd4;
    localparam logic [COLOR_WIDTH-1:0] COLOR_WHITE = 4'd5;

    typedef enum logic [1:0] {
        BRUSH_SQUARE  = 2'd0,
        BRUSH_DIAMOND = 2'd1,
        BRUSH_CIRCLE  = 2'd2,
        BRUSH_RSVD    = 2'd3
    } brush_shape_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } brush_state_t;

endpackage

// File: rtl/brush_tool_mask.sv
// Combinational in-shape test for one brush offset (dx, dy) at radius r.
// Macro BRUSH_CIRCLE_EN: when defined, the circle shape uses a true
// dx^2+dy^2 <= r^2 test; when undefined, circle falls back to square and
// no multipliers exist.
module brush_mask
    import brush_tool_pkg::*;
#(
    parameter int SW = 12,
    parameter int RW = 3
) (
    input  logic signed [SW-1:0] dx_i,
    input  logic signed [SW-1:0] dy_i,
    input  logic        [RW-1:0] r_i,
    input  brush_shape_t         shape_i,
    output logic                 in_shape_o
);

    logic [SW-1:0] adx;
    logic [SW-1:0] ady;
    logic [SW:0]   manh;

`ifdef BRUSH_CIRCLE_EN
    localparam int PW = 2*RW + 1;
    // Offsets never exceed r, so their magnitudes fit in RW bits.
    logic [PW-1:0] ax, ay, dist2, rr;
    assign ax    = PW'(adx[RW-1:0]);
    assign ay    = PW'(ady[RW-1:0]);
    assign dist2 = ax*ax + ay*ay;
    assign rr    = PW'(r_i) * PW'(r_i);
`endif

    // Magnitudes, Manhattan distance and the per-shape decision.
    always_comb begin
        adx  = dx_i[SW-1] ? -dx_i : dx_i;
        ady  = dy_i[SW-1] ? -dy_i : dy_i;
        manh = {1'b0, adx} + {1'b0, ady};
        in_shape_o = 1'b1;
        case (shape_i)
            BRUSH_DIAMOND: in_shape_o = (manh <= (SW+1)'(r_i));
`ifdef BRUSH_CIRCLE_EN
            BRUSH_CIRCLE:  in_shape_o = (dist2 <= rr);
`endif
            default:       in_shape_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/brush_tool.sv
// Brush stamp engine: latches a request, raster-scans the (2r+1)^2 box
// around the cursor and emits one registered frame-buffer write per
// in-shape, on-screen pixel, followed by a one-cycle done pulse.
// Optional circle brush: macro BRUSH_CIRCLE_EN (handled in brush_mask).
module brush_tool
    import brush_tool_pkg::*;
#(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int MAX_RADIUS = 7
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [$clog2(WIDTH)-1:0]        cursor_x,
    input  logic [$clog2(HEIGHT)-1:0]       cursor_y,
    input  logic [COLOR_WIDTH-1:0]          input_color,
    input  logic [$clog2(MAX_RADIUS+1)-1:0] radius,
    input  logic [1:0]                      shape,
    output logic [$clog2(WIDTH)-1:0]        pixel_x,
    output logic [$clog2(HEIGHT)-1:0]       pixel_y,
    output logic [COLOR_WIDTH-1:0]          pixel_color,
    output logic                            pixel_valid,
    output logic                            busy,
    output logic                            done
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int RW = $clog2(MAX_RADIUS+1);
    localparam int SW = $clog2((WIDTH > HEIGHT) ? WIDTH : HEIGHT) + 2;

    localparam logic        [RW-1:0] RMAX  = RW'(MAX_RADIUS);
    localparam logic signed [SW-1:0] W_S   = SW'(WIDTH);
    localparam logic signed [SW-1:0] H_S   = SW'(HEIGHT);
    localparam logic signed [SW-1:0] ONE_S = SW'(1);

    brush_state_t           state_q;
    logic [XW-1:0]          cx_q;
    logic [YW-1:0]          cy_q;
    logic [COLOR_WIDTH-1:0] col_q;
    brush_shape_t           shape_q;
    logic [RW-1:0]          r_q;
    logic signed [SW-1:0]   dx_q, dy_q;
    logic [XW-1:0]          px_q;
    logic [YW-1:0]          py_q;
    logic [COLOR_WIDTH-1:0] pc_q;
    logic                   pv_q, busy_q, done_q;

    logic [RW-1:0]          r_d;
    logic signed [SW-1:0]   r_s, r_start_s, cx_s, cy_s, x_s, y_s;
    logic                   on_screen, in_shape, last_cand;

    // Clamp the requested radius; all candidate arithmetic is signed and
    // wide enough that off-screen sums stay negative/oversize instead of wrapping.
    assign r_d       = (radius > RMAX) ? RMAX : radius;
    assign r_start_s = -(SW'(r_d));
    assign r_s       = SW'(r_q);
    assign cx_s      = SW'(cx_q);
    assign cy_s      = SW'(cy_q);
    assign x_s       = cx_s + dx_q;
    assign y_s       = cy_s + dy_q;
    assign on_screen = !x_s[SW-1] && (x_s < W_S) && !y_s[SW-1] && (y_s < H_S);
    assign last_cand = (dx_q == r_s) && (dy_q == r_s);

    brush_mask #(.SW(SW), .RW(RW)) u_mask (
        .dx_i       (dx_q),
        .dy_i       (dy_q),
        .r_i        (r_q),
        .shape_i    (shape_q),
        .in_shape_o (in_shape)
    );

    // Stamp FSM: accept in IDLE, one candidate per cycle in SCAN, done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            col_q   <= COLOR_NONE;
            shape_q <= BRUSH_SQUARE;
            r_q     <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            px_q    <= '0;
            py_q    <= '0;
            pc_q    <= COLOR_NONE;
            pv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pv_q   <= 1'b0;
                    pc_q   <= COLOR_NONE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (enable) begin
                        cx_q    <= cursor_x;
                        cy_q    <= cursor_y;
                        col_q   <= input_color;
                        shape_q <= brush_shape_t'(shape);
                        r_q     <= r_d;
                        dx_q    <= r_start_s;
                        dy_q    <= r_start_s;
                        state_q <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    busy_q <= 1'b1;
                    done_q <= 1'b0;
                    if (in_shape && on_screen) begin
                        pv_q <= 1'b1;
                        px_q <= x_s[XW-1:0];
                        py_q <= y_s[YW-1:0];
                        pc_q <= col_q;
                    end else begin
                        pv_q <= 1'b0;
                        pc_q <= COLOR_NONE;
                    end
                    if (last_cand) begin
                        state_q <= ST_DONE;
                    end else if (dx_q == r_s) begin
                        dx_q <= -r_s;
                        dy_q <= dy_q + ONE_S;
                    end else begin
                        dx_q <= dx_q + ONE_S;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    pv_q    <= 1'b0;
                    pc_q    <= COLOR_NONE;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pixel_x     = px_q;
    assign pixel_y     = py_q;
    assign pixel_color = pc_q;
    assign pixel_valid = pv_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_brush_tool.sv
// Self-checking bench for brush_tool on an 8x8 screen, MAX_RADIUS=3.
module tb_brush_tool;
    import brush_tool_pkg::*;

    localparam int W = 8;
    localparam int H = 8;
    localparam int MR = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [2:0] cursor_x = '0;
    logic [2:0] cursor_y = '0;
    logic [COLOR_WIDTH-1:0] input_color = COLOR_NONE;
    logic [1:0] radius = '0;
    logic [1:0] shape = '0;
    logic [2:0] pixel_x;
    logic [2:0] pixel_y;
    logic [COLOR_WIDTH-1:0] pixel_color;
    logic       pixel_valid, busy, done;

    int total = 0;
    int bad = 0;

    brush_tool #(.WIDTH(W), .HEIGHT(H), .MAX_RADIUS(MR)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .input_color(input_color),
        .radius(radius), .shape(shape),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_color(pixel_color),
        .pixel_valid(pixel_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference shape rule from the geometric definition.
    function automatic bit model_in_shape(input int dx, input int dy, input int r, input int sh);
        case (sh)
            1: return (iabs(dx) + iabs(dy)) <= r;
`ifdef BRUSH_CIRCLE_EN
            2: return (dx*dx + dy*dy) <= r*r;
`endif
            default: return 1'b1;
        endcase
    endfunction

    // Issue one stamp and check every slot against the model; optionally
    // scramble inputs mid-scan, or stop right after abort_after writes.
    task automatic run_stamp(input int cx, input int cy, input int rq, input int sh,
                             input logic [COLOR_WIDTH-1:0] col, input bit scramble,
                             input int abort_after, output int writes);
        bit ev[$];
        int ex[$];
        int ey[$];
        int r, n;
        r = (rq > MR) ? MR : rq;
        writes = 0;
        for (int dy = -r; dy <= r; dy++) begin
            for (int dx = -r; dx <= r; dx++) begin
                int x, y;
                x = cx + dx;
                y = cy + dy;
                ev.push_back(model_in_shape(dx, dy, r, sh) && x >= 0 && x < W && y >= 0 && y < H);
                ex.push_back(x);
                ey.push_back(y);
            end
        end
        n = ev.size();
        @(negedge clk);
        cursor_x = 3'(cx); cursor_y = 3'(cy); radius = 2'(rq); shape = 2'(sh);
        input_color = col; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        total++;
        if (pixel_valid !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL accept_cycle: valid=%b done=%b want 0 0", pixel_valid, done);
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL busy_slot%0d: busy=%b done=%b want 1 0", i, busy, done);
            end
            total++;
            if (pixel_valid !== ev[i]) begin
                bad++;
                $display("FAIL valid_slot%0d (c=%0d,%0d r=%0d s=%0d): got %b want %b",
                         i, cx, cy, r, sh, pixel_valid, ev[i]);
            end else if (ev[i]) begin
                total++;
                if (int'(pixel_x) != ex[i] || int'(pixel_y) != ey[i] || pixel_color !== col) begin
                    bad++;
                    $display("FAIL write_slot%0d: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                             i, pixel_x, pixel_y, pixel_color, ex[i], ey[i], col);
                end
            end else begin
                total++;
                if (pixel_color !== COLOR_NONE) begin
                    bad++;
                    $display("FAIL idle_color_slot%0d: got %0d want %0d", i, pixel_color, COLOR_NONE);
                end
            end
            if (pixel_valid === 1'b1) writes++;
            if (scramble) begin
                enable = 1'($urandom_range(0, 1));
                cursor_x = 3'($urandom_range(0, 7));
                cursor_y = 3'($urandom_range(0, 7));
                radius = 2'($urandom_range(0, 3));
                shape = 2'($urandom_range(0, 3));
                input_color = 4'($urandom_range(0, 15));
            end
            if (abort_after >= 0 && writes == abort_after) return;
        end
        @(negedge clk);
        enable = 1'b0;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || pixel_valid !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse: done=%b busy=%b valid=%b want 1 0 0", done, busy, pixel_valid);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || pixel_valid !== 1'b0) begin
            bad++;
            $display("FAIL after_done: done=%b busy=%b valid=%b want 0 0 0", done, busy, pixel_valid);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if (pixel_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pixel_x !== 3'd0 ||
            pixel_y !== 3'd0 || pixel_color !== COLOR_NONE) begin
            bad++;
            $display("FAIL reset_state: v=%b b=%b d=%b x=%0d y=%0d c=%0d want all zero/NONE",
                     pixel_valid, busy, done, pixel_x, pixel_y, pixel_color);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int w;
        run_stamp(3, 3, 0, 0, COLOR_BLUE, 1'b0, -1, w);
        total++;
        if (w != 1) begin
            bad++;
            $display("FAIL single_count: got %0d want 1", w);
        end
    endtask

    task automatic test_square();
        int w;
        run_stamp(3, 3, 1, 0, COLOR_GREEN, 1'b0, -1, w);
        total++;
        if (w != 9) begin
            bad++;
            $display("FAIL square_count: got %0d want 9", w);
        end
    endtask

    task automatic test_clip();
        int w;
        run_stamp(0, 0, 1, 0, COLOR_RED, 1'b0, -1, w);
        total++;
        if (w != 4) begin
            bad++;
            $display("FAIL clip_count: got %0d want 4", w);
        end
        run_stamp(7, 7, 3, 3, COLOR_WHITE, 1'b0, -1, w);
        total++;
        if (w != 16) begin
            bad++;
            $display("FAIL clip_far_count: got %0d want 16", w);
        end
    endtask

    task automatic test_shapes();
        int w, want;
        run_stamp(4, 4, 3, 1, COLOR_WHITE, 1'b0, -1, w);
        total++;
        if (w != 25) begin
            bad++;
            $display("FAIL diamond_count: got %0d want 25", w);
        end
`ifdef BRUSH_CIRCLE_EN
        want = 29;
`else
        want = 49;
`endif
        run_stamp(4, 4, 3, 2, COLOR_BLACK, 1'b0, -1, w);
        total++;
        if (w != want) begin
            bad++;
            $display("FAIL circle_count: got %0d want %0d", w, want);
        end
    endtask

    task automatic test_mid_scan();
        int w;
        run_stamp(3, 4, 2, 0, COLOR_BLUE, 1'b1, -1, w);
        total++;
        if (w != 25) begin
            bad++;
            $display("FAIL midscan_count: got %0d want 25", w);
        end
    endtask

    task automatic test_reset_mid_scan();
        int w;
        run_stamp(3, 3, 1, 0, COLOR_GREEN, 1'b0, 4, w);
        #1 reset = 1'b0;
        #1;
        total++;
        if (pixel_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pixel_x !== 3'd0 ||
            pixel_y !== 3'd0 || pixel_color !== COLOR_NONE) begin
            bad++;
            $display("FAIL async_reset: v=%b b=%b d=%b x=%0d y=%0d c=%0d want all zero/NONE",
                     pixel_valid, busy, done, pixel_x, pixel_y, pixel_color);
        end
        repeat (2) @(negedge clk);
        total++;
        if (pixel_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: valid=%b busy=%b want 0 0", pixel_valid, busy);
        end
        reset = 1'b1;
        run_stamp(3, 3, 1, 0, COLOR_GREEN, 1'b0, -1, w);
        total++;
        if (w != 9) begin
            bad++;
            $display("FAIL restart_count: got %0d want 9", w);
        end
    endtask

    task automatic test_random();
        int w;
        for (int k = 0; k < 25; k++) begin
            run_stamp(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), -1, w);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_square();
        test_clip();
        test_shapes();
        test_mid_scan();
        test_reset_mid_scan();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
